l2k_fill_ctrl: RTL
==================

# l2k_fill_ctrl

Cache controller that sits directly upstream of the l2k_cache data array. It accepts word read/write requests from the core, keeps a tag/valid store indexed by the same hashed index as the data array, and drives the array's write and read ports. On a miss it fetches the word from the memory bus and fills the array. Writes are write-through and write-allocate.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must equal the array's DATA_WIDTH.
- NUM_ENTRIES, 512, entry count; power of two; must equal the array's NUM_ENTRIES.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  word address (key)
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_data  out  DATA_WIDTH  read data, or written data for writes
- arr_we, arr_addr_in, arr_data_in  out  1/32/DATA_WIDTH  array write port
- arr_addr_out  out  32  array read address
- arr_data_out  in  DATA_WIDTH  array read data (combinational)
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write
- mem_addr  out  32  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ack  in  1  one-cycle completion
- mem_rdata  in  DATA_WIDTH  valid with mem_ack on reads
- hit_count, miss_count  out  32  performance counters

## Operation
- idx = l2k_hash(addr) & (NUM_ENTRIES-1). The tag store holds the full 32-bit address plus a valid bit per idx.
- The request is accepted when req_valid && req_ready. The controller latches req_we, req_addr and req_wdata into a_we, a_addr and a_wdata.
- States and transitions:
  - IDLE: accept a request; read → COMPARE, write → MEM_WR.
  - COMPARE: arr_addr_out = a_addr. A hit (valid[idx] && tag[idx]==a_addr) → RESP with rsp_data = arr_data_out and hit_count+1. A miss → MEM_RD with miss_count+1.
  - MEM_RD: mem_req=1, mem_we=0, mem_addr=a_addr. On mem_ack, capture mem_rdata → FILL.
  - MEM_WR: mem_req=1, mem_we=1, mem_addr=a_addr, mem_wdata=a_wdata. On mem_ack → FILL.
  - FILL: arr_we=1, arr_addr_in=a_addr, arr_data_in=captured or write data. Set tag[idx]=a_addr and valid[idx]=1. rsp_valid=1 with the same data. → IDLE.
  - RESP: rsp_valid=1 → IDLE.
- Writes do not touch the hit/miss counters. Both counters wrap modulo 2^32.
- A conflicting fill overwrites the previous occupant of idx. There is no eviction writeback, because the policy is write-through.
- mem_ack outside MEM_RD/MEM_WR is ignored.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, arr_we=0, arr_addr_in=0, arr_data_in=0, arr_addr_out=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, hit_count=0, miss_count=0. All valid bits clear; state IDLE.
- Read hit: accepted in cycle 0; rsp_valid in cycle 2.
- Read miss: mem_req is high from cycle 2.
- Miss or write, ack in cycle k: arr_we and rsp_valid pulse in cycle k+1; req_ready returns in cycle k+2.
- mem_req, mem_addr, mem_we and mem_wdata stay stable from assertion through the ack cycle. mem_req drops in the cycle after ack.
- mem_ack arriving in the first cycle of mem_req is legal.
- rst mid-operation: in the next cycle state is IDLE, mem_req=0, no arr_we, and no rsp_valid. The pending request is discarded and all valid bits are cleared.
- Back-to-back requests: a new request is accepted in the cycle after rsp_valid.

## Structure
- Package l2k_pkg holds:
  - the l2k_hash function, shared with l2k_cache so that both compute the same idx;
  - the state enum l2k_fill_state_t;
  - a default constant for NUM_ENTRIES.
- Sub-module l2k_tag_ram holds the tag and valid arrays. It has one read port, one write port and a synchronous clear on rst.

## Test plan
- Reset, then read 0x1000 → miss; mem_req with mem_addr=0x1000. Ack with 0xDEADBEEF → arr_we pulse, rsp_data=0xDEADBEEF, miss_count=1.
- Read 0x1000 again → no mem_req; rsp_valid 2 cycles after accept with 0xDEADBEEF; hit_count=1.
- Write 0x2000=0x12345678 with ack delayed 5 cycles → mem signals stable throughout. A following read of 0x2000 hits with 0x12345678; counters unchanged by the write.
- Two addresses with the same idx (bench computes them via l2k_hash): fill A, fill B, read A → miss, refetch from memory.
- Assert rst while in MEM_RD → mem_req low next cycle, no rsp_valid. A stray mem_ack afterwards is ignored. A subsequent read of a previously cached address misses.
- 100 random reads/writes over 16 addresses against a reference memory model → every rsp_data matches, and the counters match the model.

Source files
------------

// File: rtl/l2k_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2k_pkg : shared hash, fill-controller state type, default sizes      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package l2k_pkg;

    localparam int C_NUM_ENTRIES_DEFAULT = 512;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMPARE = 3'd1,
        ST_MEM_RD  = 3'd2,
        ST_MEM_WR  = 3'd3,
        ST_FILL    = 3'd4,
        ST_RESP    = 3'd5
    } l2k_fill_state_t;

    // XOR-fold so every address bit influences the low index bits.
    function automatic logic [31:0] l2k_hash(input logic [31:0] addr);
        return addr ^ (addr >> 9) ^ (addr >> 18) ^ (addr >> 27);
    endfunction

endpackage : l2k_pkg
`default_nettype wire

// File: rtl/l2k_tag_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2k_tag_ram : tag + valid store, 1 read / 1 write port, sync clear    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module l2k_tag_ram
    import l2k_pkg::*;
#(
    parameter int NUM_ENTRIES = C_NUM_ENTRIES_DEFAULT,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_tag,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_tag
);

    logic [31:0]            r_tag [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

    // Tags need no reset: a stale tag is harmless while its valid bit is clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_idx] <= wr_tag;
        end
    end

    assign rd_tag   = r_tag[rd_idx];
    assign rd_valid = r_valid[rd_idx];

endmodule : l2k_tag_ram
`default_nettype wire

// File: rtl/l2k_fill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2k_fill_ctrl : write-through / write-allocate fill controller        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module l2k_fill_ctrl
    import l2k_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_ENTRIES = C_NUM_ENTRIES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  arr_we,
    output logic [31:0]           arr_addr_in,
    output logic [DATA_WIDTH-1:0] arr_data_in,
    output logic [31:0]           arr_addr_out,
    input  logic [DATA_WIDTH-1:0] arr_data_out,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    l2k_fill_state_t       r_state;
    l2k_fill_state_t       w_next_state;
    logic [31:0]           r_a_addr;
    // Holds write data, hit data or fetched data: whichever the response returns.
    logic [DATA_WIDTH-1:0] r_data;
    logic [31:0]           r_hit_count;
    logic [31:0]           r_miss_count;

    logic [IDX_W-1:0]      w_idx;
    logic [31:0]           w_tag;
    logic                  w_valid;
    logic                  w_hit;
    logic                  w_tag_we;

    assign w_idx = IDX_W'(l2k_hash(r_a_addr) & (NUM_ENTRIES - 1));
    assign w_hit = w_valid && (w_tag == r_a_addr);

    l2k_tag_ram #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_tag_ram (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (w_idx),
        .rd_tag   (w_tag),
        .rd_valid (w_valid),
        .wr_en    (w_tag_we),
        .wr_idx   (w_idx),
        .wr_tag   (r_a_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (req_valid) w_next_state = req_we ? ST_MEM_WR : ST_COMPARE;
            ST_COMPARE: w_next_state = w_hit ? ST_RESP : ST_MEM_RD;
            ST_MEM_RD:  if (mem_ack) w_next_state = ST_FILL;
            ST_MEM_WR:  if (mem_ack) w_next_state = ST_FILL;
            ST_FILL:    w_next_state = ST_IDLE;
            ST_RESP:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        arr_we       = 1'b0;
        arr_addr_in  = '0;
        arr_data_in  = '0;
        arr_addr_out = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w_tag_we     = 1'b0;
        case (r_state)
            ST_IDLE:    req_ready = 1'b1;
            ST_COMPARE: arr_addr_out = r_a_addr;
            ST_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = r_a_addr;
            end
            ST_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_a_addr;
                mem_wdata = r_data;
            end
            ST_FILL: begin
                arr_we      = 1'b1;
                arr_addr_in = r_a_addr;
                arr_data_in = r_data;
                w_tag_we    = 1'b1;
                rsp_valid   = 1'b1;
            end
            ST_RESP:    rsp_valid = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_addr     <= '0;
            r_data       <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_a_addr <= req_addr;
                        if (req_we) r_data <= req_wdata;
                    end
                end
                ST_COMPARE: begin
                    if (w_hit) begin
                        r_data      <= arr_data_out;
                        r_hit_count <= r_hit_count + 32'd1;
                    end else begin
                        r_miss_count <= r_miss_count + 32'd1;
                    end
                end
                ST_MEM_RD: if (mem_ack) r_data <= mem_rdata;
                default:   ;
            endcase
        end
    end

    assign rsp_data   = r_data;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule : l2k_fill_ctrl
`default_nettype wire
